// File: rtl/bounded_updown_counter_if.sv
// Control/status bundle for bounded_updown_counter.
// Optional snapshot port pair is present only when CNT_SNAPSHOT_EN is defined.
interface bounded_updown_counter_if #(
   parameter int WIDTH = 4
);
   logic             load;
   logic             up;
   logic             down;
   logic [WIDTH-1:0] IN;
   logic [WIDTH-1:0] step;
   logic [WIDTH-1:0] min_val;
   logic [WIDTH-1:0] max_val;
   logic [1:0]       mode;
   logic             clr_ovf;
   logic [WIDTH-1:0] count;
   logic             high;
   logic             low;
   logic             tc_up;
   logic             tc_dn;
   logic             ovf;
   logic             halted;
   logic             cfg_err;
`ifdef CNT_SNAPSHOT_EN
   logic             snap;
   logic [WIDTH-1:0] snap_val;

   modport master (
      output load, up, down, IN, step, min_val, max_val, mode, clr_ovf, snap,
      input  count, high, low, tc_up, tc_dn, ovf, halted, cfg_err, snap_val
   );
   modport slave (
      input  load, up, down, IN, step, min_val, max_val, mode, clr_ovf, snap,
      output count, high, low, tc_up, tc_dn, ovf, halted, cfg_err, snap_val
   );
`else
   modport master (
      output load, up, down, IN, step, min_val, max_val, mode, clr_ovf,
      input  count, high, low, tc_up, tc_dn, ovf, halted, cfg_err
   );
   modport slave (
      input  load, up, down, IN, step, min_val, max_val, mode, clr_ovf,
      output count, high, low, tc_up, tc_dn, ovf, halted, cfg_err
   );
`endif
endinterface

// File: rtl/bounded_updown_counter.sv
// Bounded up/down counter with load, programmable bounds/step and
// saturate / wrap / one-shot limit modes.
// Optional feature macro: CNT_SNAPSHOT_EN (snap input, snap_val register).
//
// state | meaning
// RUN   | up/down steps are applied
// HALT  | one-shot limit reached; up/down ignored until load or rst
module bounded_updown_counter #(
   parameter int WIDTH     = 4,
   parameter int RESET_VAL = 0
) (
   input logic                    clk,
   input logic                    rst,
   bounded_updown_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);

   typedef enum logic {RUN, HALT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tcu_q, tcu_d, tcd_q, tcd_d;
   logic             ovf_q, ovf_set;

   logic [WIDTH-1:0] step_eff;
   logic [WIDTH:0]   up_sum;
   logic [WIDTH:0]   dn_diff;
   logic             dn_neg;
   logic             cfg_bad;
   logic             mode_wrap, mode_one;
   logic [WIDTH-1:0] load_clamped;

   // Shared arithmetic and decode; sums carry one extra bit so crossings
   // past either end of the range are visible.
   always_comb begin
      step_eff     = (bus.step == '0) ? WIDTH'(1) : bus.step;
      up_sum       = {1'b0, cnt_q} + {1'b0, step_eff};
      dn_diff      = {1'b0, cnt_q} - {1'b0, step_eff};
      dn_neg       = dn_diff[WIDTH];
      cfg_bad      = bus.min_val > bus.max_val;
      mode_wrap    = bus.mode == 2'b01;
      mode_one     = bus.mode == 2'b10;
      load_clamped = (bus.IN < bus.min_val) ? bus.min_val :
                     (bus.IN > bus.max_val) ? bus.max_val : bus.IN;
   end

   // Next-state, next-count and event decode in priority order load > down > up.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tcu_d   = 1'b0;
      tcd_d   = 1'b0;
      ovf_set = 1'b0;
      if (cfg_bad) begin
         cnt_d = bus.min_val;
      end else if (bus.load) begin
         cnt_d   = load_clamped;
         state_d = RUN;
      end else if (state_q == RUN && bus.down) begin
         if (dn_neg || dn_diff[WIDTH-1:0] <= bus.min_val) begin
            tcd_d   = 1'b1;
            ovf_set = dn_neg || (dn_diff[WIDTH-1:0] < bus.min_val);
            cnt_d   = (mode_wrap && ovf_set) ? bus.max_val : bus.min_val;
            if (mode_one) state_d = HALT;
         end else begin
            // a count stranded above a lowered max is pulled back in
            cnt_d = (dn_diff[WIDTH-1:0] > bus.max_val) ? bus.max_val
                                                       : dn_diff[WIDTH-1:0];
         end
      end else if (state_q == RUN && bus.up) begin
         if (up_sum >= {1'b0, bus.max_val}) begin
            tcu_d   = 1'b1;
            ovf_set = up_sum > {1'b0, bus.max_val};
            cnt_d   = (mode_wrap && ovf_set) ? bus.min_val : bus.max_val;
            if (mode_one) state_d = HALT;
         end else begin
            cnt_d = (up_sum[WIDTH-1:0] < bus.min_val) ? bus.min_val
                                                      : up_sum[WIDTH-1:0];
         end
      end
   end

   // State, count, terminal-count pulses and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= RST_CNT;
         tcu_q   <= 1'b0;
         tcd_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tcu_q   <= tcu_d;
         tcd_q   <= tcd_d;
         if (ovf_set)          ovf_q <= 1'b1;
         else if (bus.clr_ovf) ovf_q <= 1'b0;
      end
   end

`ifdef CNT_SNAPSHOT_EN
   logic [WIDTH-1:0] snap_q;

   // Capture the pre-update count on snap.
   always_ff @(posedge clk) begin
      if (rst)           snap_q <= RST_CNT;
      else if (bus.snap) snap_q <= cnt_q;
   end

   assign bus.snap_val = snap_q;
`endif

   assign bus.count   = cnt_q;
   assign bus.high    = cnt_q == bus.max_val;
   assign bus.low     = cnt_q == bus.min_val;
   assign bus.tc_up   = tcu_q;
   assign bus.tc_dn   = tcd_q;
   assign bus.ovf     = ovf_q;
   assign bus.halted  = state_q == HALT;
   assign bus.cfg_err = cfg_bad;
endmodule
